// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared geometry, colour types and blitter state encoding
package gfx_pkg;

    localparam int BUFFER_WIDTH  = 160;
    localparam int BUFFER_HEIGHT = 120;
    localparam int LAYER_WIDTH   = 296;
    localparam int LAYER_HEIGHT  = 120;
    localparam int W             = 8;
    localparam int VRAM_L        = BUFFER_WIDTH * BUFFER_HEIGHT;

    localparam int OFS_W   = $clog2(LAYER_WIDTH) + 1;
    localparam int SC_W    = $clog2(LAYER_WIDTH);
    localparam int ROM_AW  = $clog2(LAYER_WIDTH * LAYER_HEIGHT);
    localparam int VRAM_AW = $clog2(VRAM_L);
    localparam int ROW_W   = $clog2(BUFFER_HEIGHT);
    localparam int COL_W   = $clog2(BUFFER_WIDTH);

    typedef logic [W-1:0] color8_t;

    localparam color8_t KEY      = 8'h00;
    localparam color8_t BG_COLOR = 8'hc9;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} blit_state_t;

    // sc*LAYER_HEIGHT as a sum of constant shifts, so no multiplier is inferred
    function automatic logic [ROM_AW-1:0] col_base(input logic [SC_W-1:0] sc);
        logic [ROM_AW-1:0] acc;
        logic [ROM_AW-1:0] ext;
        acc = '0;
        ext = ROM_AW'(sc);
        for (int b = 0; b < ROM_AW; b++) begin
            if (((LAYER_HEIGHT >> b) & 1) != 0) begin
                acc = acc + (ext << b);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/composite_mux.sv
// rtl/composite_mux.sv - two-input priority mux: front pixel wins unless transparent
module composite_mux
    import gfx_pkg::*;
(
    input  color8_t front,
    input  color8_t back,
    output color8_t pixel
);

    assign pixel = (front != KEY) ? front : back;

endmodule

// File: rtl/layer_col_tracker.sv
// rtl/layer_col_tracker.sv - per-layer source column and column base tracking
module layer_col_tracker
    import gfx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [OFS_W-1:0]  offset,
    input  logic [ROW_W-1:0]  row,
    output logic [ROM_AW-1:0] addr
);

    logic [SC_W-1:0]   sc;
    logic [ROM_AW-1:0] base;
    logic [SC_W-1:0]   start_sc;

    always_comb begin
        start_sc = offset[SC_W-1:0];
        if (offset >= OFS_W'(LAYER_WIDTH)) begin
            start_sc = SC_W'(offset - OFS_W'(LAYER_WIDTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc   <= '0;
            base <= '0;
        end else if (load) begin
            sc   <= start_sc;
            base <= col_base(start_sc);
        end else if (advance) begin
            // horizontal wrap of the layer
            if (sc == SC_W'(LAYER_WIDTH - 1)) begin
                sc   <= '0;
                base <= '0;
            end else begin
                sc   <= sc + SC_W'(1);
                base <= base + ROM_AW'(LAYER_HEIGHT);
            end
        end
    end

    assign addr = base + ROM_AW'(row);

endmodule

// File: rtl/layer_blit_engine.sv
// rtl/layer_blit_engine.sv - composites three scrolled layer ROMs into VRAM, one frame per start
module layer_blit_engine
    import gfx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OFS_W-1:0]   offset0,
    input  logic [OFS_W-1:0]   offset1,
    input  logic [OFS_W-1:0]   offset2,
    output logic               busy,
    output logic               done,
    output logic [ROM_AW-1:0]  rom0_addr,
    output logic [ROM_AW-1:0]  rom1_addr,
    output logic [ROM_AW-1:0]  rom2_addr,
    input  logic [W-1:0]       rom0_data,
    input  logic [W-1:0]       rom1_data,
    input  logic [W-1:0]       rom2_data,
    output logic               vram_wr_ena,
    output logic [VRAM_AW-1:0] vram_wr_addr,
    output logic [W-1:0]       vram_wr_data
);

    blit_state_t        state;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [VRAM_AW-1:0] p;
    logic [VRAM_AW-1:0] p_d1;
    logic               v_d1;
    logic               drain_cnt;
    logic               load;
    logic               advance;
    logic               col_end;
    color8_t            back2;
    color8_t            mid;
    color8_t            pixel;

    assign load    = (state == S_IDLE) && start;
    assign col_end = (row == ROW_W'(BUFFER_HEIGHT - 1));
    assign advance = (state == S_RUN) && col_end;

    layer_col_tracker u_trk0 (.clk(clk), .rst(rst), .load(load), .advance(advance),
                              .offset(offset0), .row(row), .addr(rom0_addr));
    layer_col_tracker u_trk1 (.clk(clk), .rst(rst), .load(load), .advance(advance),
                              .offset(offset1), .row(row), .addr(rom1_addr));
    layer_col_tracker u_trk2 (.clk(clk), .rst(rst), .load(load), .advance(advance),
                              .offset(offset2), .row(row), .addr(rom2_addr));

    assign back2 = (rom2_data != KEY) ? rom2_data : BG_COLOR;

    composite_mux u_mix1 (.front(rom1_data), .back(back2), .pixel(mid));
    composite_mux u_mix0 (.front(rom0_data), .back(mid),   .pixel(pixel));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            row          <= '0;
            col          <= '0;
            p            <= '0;
            p_d1         <= '0;
            v_d1         <= 1'b0;
            drain_cnt    <= 1'b0;
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
        end else begin
            done <= 1'b0;
            // two-stage write pipeline: ROM read latency plus the output register
            v_d1         <= (state == S_RUN);
            p_d1         <= p;
            vram_wr_ena  <= v_d1;
            vram_wr_addr <= p_d1;
            vram_wr_data <= pixel;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                        p     <= '0;
                    end
                end
                S_RUN: begin
                    p <= p + VRAM_AW'(1);
                    if (col_end) begin
                        row <= '0;
                        col <= col + COL_W'(1);
                        if (col == COL_W'(BUFFER_WIDTH - 1)) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_blit_engine.sv
// tb/tb_layer_blit_engine.sv - directed self-checking bench for layer_blit_engine
module tb_layer_blit_engine;

    localparam int LW = 296;
    localparam int LH = 120;
    localparam int BH = 120;
    localparam int L  = 160 * 120;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  offset0, offset1, offset2;
    logic        busy, done;
    logic [15:0] rom0_addr, rom1_addr, rom2_addr;
    logic [7:0]  rom0_data, rom1_data, rom2_data;
    logic        vram_wr_ena;
    logic [14:0] vram_wr_addr;
    logic [7:0]  vram_wr_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;
    int chain_s0;
    int nxt0, nxt1, nxt2;
    int cap_data [0:7];
    int cap_a0_11400, cap_a0_11520, cap_a1_119;

    layer_blit_engine dut (
        .clk(clk), .rst(rst), .start(start),
        .offset0(offset0), .offset1(offset1), .offset2(offset2),
        .busy(busy), .done(done),
        .rom0_addr(rom0_addr), .rom1_addr(rom1_addr), .rom2_addr(rom2_addr),
        .rom0_data(rom0_data), .rom1_data(rom1_data), .rom2_data(rom2_data),
        .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr), .vram_wr_data(vram_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] romf(input int md, input int layer, input logic [15:0] a);
        if (md == 0) return a[7:0];
        case (layer)
            0:       return (a[1:0] == 2'd0) ? 8'h56 : 8'h00;
            1:       return (a[1:0] == 2'd1) ? 8'h12 : 8'h00;
            default: return (a[1:0] != 2'd3) ? 8'h34 : 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        rom0_data <= romf(mode, 0, rom0_addr);
        rom1_data <= romf(mode, 1, rom1_addr);
        rom2_data <= romf(mode, 2, rom2_addr);
    end

    function automatic int ea(input int off, input int p);
        int c, r;
        c = p / BH;
        r = p % BH;
        return ((off + c) % LW) * LH + r;
    endfunction

    function automatic int expd(input int md, input int r0, input int r1, input int r2, input int p);
        logic [7:0] d0, d1, d2;
        d0 = romf(md, 0, 16'(ea(r0, p)));
        d1 = romf(md, 1, 16'(ea(r1, p)));
        d2 = romf(md, 2, 16'(ea(r2, p)));
        if (d0 != 8'h00) return int'(d0);
        if (d1 != 8'h00) return int'(d1);
        if (d2 != 8'h00) return int'(d2);
        return 32'hc9;
    endfunction

    task automatic chk(input string tag, input int obs, input int req);
        total++;
        if (obs != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, req, req);
        end
    endtask

    task automatic run_frame(input int o0, input int o1, input int o2, input int md,
                             input bit pre, input bit chain, input bit perturb, input int abort_at);
        int s0, rel, p, wcount, first_w, done_rel, done_cnt, a_err, w_err, b_err;
        int r0, r1, r2;
        bit fin;
        r0 = (o0 >= LW) ? o0 - LW : o0;
        r1 = (o1 >= LW) ? o1 - LW : o1;
        r2 = (o2 >= LW) ? o2 - LW : o2;
        mode = md;
        if (!pre) begin
            @(negedge clk);
            offset0 = 10'(o0); offset1 = 10'(o1); offset2 = 10'(o2);
            start = 1'b1;
            s0 = cyc;
        end else begin
            s0 = chain_s0;
        end
        wcount = 0; first_w = -1; done_rel = -1; done_cnt = 0;
        a_err = 0; w_err = 0; b_err = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            rel = cyc - s0;
            start = 1'b0;
            if (perturb && (rel == 10 || rel == 5000)) start = 1'b1;
            if (perturb && rel == 100) begin
                offset0 = 10'd50; offset1 = 10'd50; offset2 = 10'd50;
            end
            if (abort_at > 0 && rel == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_wr_ena", int'(vram_wr_ena), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_wr_addr", int'(vram_wr_addr), 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (int'(busy) != ((rel >= 1 && rel <= L + 2) ? 1 : 0)) b_err++;
            if (rel >= 1 && rel <= L) begin
                p = rel - 1;
                if (int'(rom0_addr) != ea(r0, p)) a_err++;
                if (int'(rom1_addr) != ea(r1, p)) a_err++;
                if (int'(rom2_addr) != ea(r2, p)) a_err++;
                if (p == 11400) cap_a0_11400 = int'(rom0_addr);
                if (p == 11520) cap_a0_11520 = int'(rom0_addr);
                if (p == 119)   cap_a1_119   = int'(rom1_addr);
            end
            if (vram_wr_ena) begin
                if (first_w < 0) first_w = rel;
                if (wcount >= L) w_err++;
                else if (int'(vram_wr_addr) != wcount || rel != 3 + wcount ||
                         int'(vram_wr_data) != expd(md, r0, r1, r2, wcount)) w_err++;
                if (wcount < 8) cap_data[wcount] = int'(vram_wr_data);
                wcount++;
            end
            if (done) begin
                done_cnt++;
                if (done_rel < 0) done_rel = rel;
                if (chain) begin
                    offset0 = 10'(nxt0); offset1 = 10'(nxt1); offset2 = 10'(nxt2);
                    start = 1'b1;
                    chain_s0 = cyc;
                    fin = 1'b1;
                end
            end
            if (rel >= L + 8) fin = 1'b1;
        end
        chk("write_count", wcount, L);
        chk("first_write_cycle", first_w, 3);
        chk("done_cycle", done_rel, L + 3);
        chk("done_count", done_cnt, 1);
        chk("rom_addr_errors", a_err, 0);
        chk("write_errors", w_err, 0);
        chk("busy_errors", b_err, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        offset0 = '0; offset1 = '0; offset2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wr_ena", int'(vram_wr_ena), 0);
        chk("reset_wr_addr", int'(vram_wr_addr), 0);
        chk("reset_wr_data", int'(vram_wr_data), 0);
        chk("reset_rom0_addr", int'(rom0_addr), 0);
        rst = 1'b0;

        nxt0 = 200; nxt1 = 0; nxt2 = 0;
        run_frame(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
        chk("p0_all_key_bg", cap_data[0], 32'hc9);
        chk("p5_data", cap_data[5], 32'h05);

        run_frame(200, 0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        chk("wrap_rom0_p11520", cap_a0_11520, 0);
        chk("pre_wrap_rom0_p11400", cap_a0_11400, 35400);

        run_frame(0, 296, 0, 0, 1'b0, 1'b0, 1'b1, 0);
        chk("offset296_rom1_p119", cap_a1_119, 119);

        run_frame(7, 8, 9, 0, 1'b0, 1'b0, 1'b0, 5000);

        run_frame(0, 0, 0, 1, 1'b0, 1'b0, 1'b0, 0);
        chk("prio_front", cap_data[0], 32'h56);
        chk("prio_mid", cap_data[1], 32'h12);
        chk("prio_back", cap_data[2], 32'h34);
        chk("prio_bg", cap_data[3], 32'hc9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
